// File: rtl/sum_tx_pkg.sv
// Shared types and constants for the sum/latch UART frame scheduler.
// Build option: SUM_TX_CHECKSUM_EN selects the 4-byte frame with a trailing
// XOR checksum byte; leaving it undefined gives the 3-byte frame.
package sum_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        CHK  = 3'd4
    } state_e;

`ifdef SUM_TX_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    localparam logic [7:0] DEFAULT_HDR = 8'hA5;

`ifdef SUM_TX_CHECKSUM_EN
    // Checksum byte closing the frame: XOR of the three preceding bytes.
    function automatic logic [7:0] frame_chk(input logic [7:0] h,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
        return h ^ hi ^ lo;
    endfunction
`endif

endpackage

// File: rtl/sum_acc.sv
// Operand accumulator: wraps modulo 2^ACC_W, a carry-out sets a sticky
// overflow flag, and clear takes priority over a same-cycle add.
module sum_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_valid_i,
    input  logic [7:0]       add_data_i,
    input  logic             clr_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_ext;

    assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, add_data_i};

    // Next accumulator value: clear first, then add with carry detection.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_valid_i) begin
            acc_d = sum_ext[ACC_W-1:0];
            ovf_d = ovf_q | sum_ext[ACC_W];
        end
    end

    // Accumulator and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/sum_tx_sched.sv
// Frame scheduler between the accumulator and a byte-wide UART transmitter.
// A latch request snapshots the accumulator and sends HDR, sum[15:8],
// sum[7:0] (and, with SUM_TX_CHECKSUM_EN defined, an XOR checksum byte)
// over a valid/ready handshake. Requests arriving mid-frame park in a
// one-deep pending slot; further ones are dropped and counted.
module sum_tx_sched
    import sum_tx_pkg::*;
#(
    parameter int         ACC_W    = 16,
    parameter logic [7:0] HDR_BYTE = DEFAULT_HDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_valid,
    input  logic [7:0]       add_data,
    input  logic             clr,
    input  logic             latch_req,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [ACC_W-1:0] sum_latched,
    output logic             ovf,
    output logic [7:0]       drop_cnt
);

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic [7:0]       drop_q, drop_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] acc;
    logic [15:0]      sum16;
    logic             frame_end;
    logic             launch;
    logic [7:0]       tx_byte;

    sum_acc #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .add_valid_i(add_valid),
        .add_data_i (add_data),
        .clr_i      (clr),
        .acc_o      (acc),
        .ovf_o      (ovf)
    );

    // Snapshot zero-extended to the fixed 16-bit frame field.
    always_comb begin
        sum16            = '0;
        sum16[ACC_W-1:0] = sum_q;
    end

    // Byte presented for the current frame position; zero when idle.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            HDR:     tx_byte = HDR_BYTE;
            HI:      tx_byte = sum16[15:8];
            LO:      tx_byte = sum16[7:0];
`ifdef SUM_TX_CHECKSUM_EN
            CHK:     tx_byte = frame_chk(HDR_BYTE, sum16[15:8], sum16[7:0]);
`endif
            default: tx_byte = 8'h00;
        endcase
    end

`ifdef SUM_TX_CHECKSUM_EN
    assign frame_end = (state_q == CHK) && tx_ready;
`else
    assign frame_end = (state_q == LO) && tx_ready;
`endif

    // Frame sequencing, pending slot, drop counting and snapshot capture.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        sum_d   = sum_q;
        launch  = 1'b0;

        case (state_q)
            IDLE: begin
                // A request parked at the previous frame end launches here;
                // a fresh request in the same cycle takes over the slot.
                if (latch_req || pend_q) begin
                    launch = 1'b1;
                    pend_d = pend_q & latch_req;
                end
            end
            HDR:     if (tx_ready) state_d = HI;
            HI:      if (tx_ready) state_d = LO;
`ifdef SUM_TX_CHECKSUM_EN
            LO:      if (tx_ready) state_d = CHK;
            CHK:     state_d = state_q;
`else
            LO:      state_d = state_q;
`endif
            default: state_d = IDLE;
        endcase

        // Requests while a frame is running go to the slot or are dropped.
        if (state_q != IDLE && latch_req) begin
            if (pend_q) begin
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
                pend_d = 1'b1;
            end
        end

        // Last byte accepted: chain the parked request without a bubble.
        if (frame_end) begin
            if (pend_q) begin
                launch = 1'b1;
                pend_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end

        if (launch) begin
            state_d = HDR;
            sum_d   = acc;
        end
    end

    // State, pending slot, drop counter and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            drop_q  <= 8'h00;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            sum_q   <= sum_d;
        end
    end

    assign tx_data     = tx_byte;
    assign tx_valid    = (state_q != IDLE);
    assign busy        = (state_q != IDLE) || pend_q;
    assign sum_latched = sum_q;
    assign drop_cnt    = drop_q;

endmodule
